// File: rtl/branch_resolve_unit.sv
// Resolves RV32 conditional branches against a 2-bit saturating BHT prediction and updates the table.
// Latency: prediction lookup is combinational; resolution results are registered one cycle after capture.
// Backpressure: ex_stall freezes capture, results, BHT and perf counters; there is no ready handshake.
module branch_resolve_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [2:0]        ex_func3,
    input  logic [XLEN-1:0]   ex_rs1,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    output logic              res_valid,
    output logic              res_taken,
    output logic              res_mispredict,
    output logic [XLEN-1:0]   res_redirect_pc,
    output logic              res_illegal,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]        r_bht [BHT_DEPTH];
    logic              r_res_valid;
    logic              r_res_taken;
    logic              r_res_mispredict;
    logic [XLEN-1:0]   r_res_redirect_pc;
    logic              r_res_illegal;
    logic [PERF_W-1:0] r_perf_branches;
    logic [PERF_W-1:0] r_perf_mispred;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic              w_cond;
    logic              w_illegal;
    logic              w_capture;
    logic              w_mispred;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_redirect;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_nxt;
    logic              w_unused_if_pc;

    // Word-aligned PCs index the table; upper PC bits alias by design.
    assign w_if_idx       = if_pc[IDX_W+1:2];
    assign w_ex_idx       = ex_pc[IDX_W+1:2];
    assign w_unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign if_pred_taken = r_bht[w_if_idx][1];

    // Branch condition per func3; the two unused encodings resolve as not taken and flag illegal.
    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        case (ex_func3)
            3'b000:  w_cond = (ex_rs1 == ex_rs2);
            3'b001:  w_cond = (ex_rs1 != ex_rs2);
            3'b100:  w_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  w_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  w_cond = (ex_rs1 <  ex_rs2);
            3'b111:  w_cond = (ex_rs1 >= ex_rs2);
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_capture  = ex_valid & ~ex_stall;
    assign w_mispred  = w_cond ^ ex_pred_taken;
    assign w_pc_plus4 = ex_pc + XLEN'(4);
    assign w_redirect = w_mispred ? (w_cond ? ex_target : w_pc_plus4) : '0;
    assign w_ctr_cur  = r_bht[w_ex_idx];

    // Saturating two-bit counter step towards the actual outcome.
    always_comb begin
        w_ctr_nxt = w_ctr_cur;
        if (w_cond) begin
            if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'd1;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'd1;
        end
    end

    // Result registers: load on capture, drop the pulse flags when idle, freeze on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid       <= 1'b0;
            r_res_taken       <= 1'b0;
            r_res_mispredict  <= 1'b0;
            r_res_redirect_pc <= '0;
            r_res_illegal     <= 1'b0;
        end else if (!ex_stall) begin
            if (ex_valid) begin
                r_res_valid       <= 1'b1;
                r_res_taken       <= w_cond;
                r_res_mispredict  <= w_mispred;
                r_res_redirect_pc <= w_redirect;
                r_res_illegal     <= w_illegal;
            end else begin
                r_res_valid      <= 1'b0;
                r_res_mispredict <= 1'b0;
                r_res_illegal    <= 1'b0;
            end
        end
    end

    // BHT training on legal captured branches only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CNT_INIT;
        end else if (w_capture && !w_illegal) begin
            r_bht[w_ex_idx] <= w_ctr_nxt;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_branches <= '0;
            r_perf_mispred  <= '0;
        end else if (w_capture) begin
            if (r_perf_branches != {PERF_W{1'b1}})
                r_perf_branches <= r_perf_branches + PERF_W'(1);
            if (w_mispred && (r_perf_mispred != {PERF_W{1'b1}}))
                r_perf_mispred <= r_perf_mispred + PERF_W'(1);
        end
    end

    assign res_valid       = r_res_valid;
    assign res_taken       = r_res_taken;
    assign res_mispredict  = r_res_mispredict;
    assign res_redirect_pc = r_res_redirect_pc;
    assign res_illegal     = r_res_illegal;
    assign perf_branches   = r_perf_branches;
    assign perf_mispred    = r_perf_mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a result scoreboard.
// Latency: expects each captured branch on the outputs one clock after capture.
// Backpressure: exercises ex_stall hold behaviour and a narrow-perf-counter instance for saturation.
module tb_branch_resolve_unit;

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [2:0]  ex_func3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_target;
    logic        ex_pred_taken;
    logic        res_valid, res_taken, res_mispredict, res_illegal;
    logic [31:0] res_redirect_pc;
    logic [31:0] perf_branches, perf_mispred;

    logic        s_pred_taken, s_res_valid, s_res_taken, s_res_mispredict, s_res_illegal;
    logic [31:0] s_res_redirect_pc;
    logic [3:0]  s_perf_branches, s_perf_mispred;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_func3(ex_func3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
        .res_mispredict(res_mispredict), .res_redirect_pc(res_redirect_pc),
        .res_illegal(res_illegal), .perf_branches(perf_branches), .perf_mispred(perf_mispred)
    );

    branch_resolve_unit #(.PERF_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_func3(ex_func3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .res_valid(s_res_valid), .res_taken(s_res_taken),
        .res_mispredict(s_res_mispredict), .res_redirect_pc(s_res_redirect_pc),
        .res_illegal(s_res_illegal), .perf_branches(s_perf_branches), .perf_mispred(s_perf_mispred)
    );

    typedef struct packed {
        logic        taken;
        logic        mispred;
        logic        illegal;
        logic [31:0] redir;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;
    int   exp_br = 0;
    int   exp_mp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            F_BEQ:   return a == b;
            F_BNE:   return a != b;
            F_BLT:   return $signed(a) <  $signed(b);
            F_BGE:   return $signed(a) >= $signed(b);
            F_BLTU:  return a <  b;
            F_BGEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        ex_valid = 1'b1; ex_func3 = f3; ex_rs1 = a; ex_rs2 = b;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    // Drive a branch that will be captured at the next edge and record its expected result.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        exp_t e;
        drive(f3, a, b, pc, tgt, pred);
        e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
        e.taken   = ref_cond(f3, a, b);
        e.mispred = e.taken ^ pred;
        e.redir   = e.mispred ? (e.taken ? tgt : pc + 32'd4) : 32'd0;
        sb_q.push_back(e);
        exp_br++;
        if (e.mispred) exp_mp++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected a pending result", tag);
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            chk({tag, ".valid"},   res_valid,       1'b1);
            chk({tag, ".taken"},   res_taken,       e.taken);
            chk({tag, ".mispred"}, res_mispredict,  e.mispred);
            chk({tag, ".redir"},   res_redirect_pc, e.redir);
            chk({tag, ".illegal"}, res_illegal,     e.illegal);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        issue(f3, a, b, pc, tgt, pred);
        cycle();
        check_res(tag);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic expv);
        if_pc = pc;
        #1;
        chk(tag, if_pred_taken, expv);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_stall = 1'b0; ex_func3 = 3'b000;
        ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; if_pc = '0;
        #2;
        // Reset state
        chk("rst.valid", res_valid, 1'b0);
        chk("rst.redir", res_redirect_pc, 32'd0);
        chk("rst.perf_br", perf_branches, 32'd0);
        chk("rst.perf_mp", perf_mispred, 32'd0);
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #0.1;
            chk("rst.pred", if_pred_taken, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Signed vs unsigned compare of the same operands
        step("bltu", F_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b0);
        step("blt",  F_BLT,  32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b0);
        step("bge",  F_BGE,  32'd1, 32'hFFFF_FFFF, 32'h104, 32'h90, 1'b1);
        step("bgeu", F_BGEU, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h90, 1'b1);
        step("blt2", F_BLT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h108, 32'h70, 1'b0);
        ex_valid = 1'b0;
        cycle();
        chk("idle.valid",   res_valid,       1'b0);
        chk("idle.mispred", res_mispredict,  1'b0);
        chk("idle.illegal", res_illegal,     1'b0);
        chk("idle.taken",   res_taken,       last_exp.taken);
        chk("idle.redir",   res_redirect_pc, last_exp.redir);

        // Train entry 16 taken three times, then two not-taken steps show saturation at 11
        check_pred("beq.pred0", 32'h40, 1'b0);
        step("beq1", F_BEQ, 32'd5, 32'd5, 32'h40, 32'h200, 1'b0);
        check_pred("beq.pred1", 32'h40, 1'b1);
        step("beq2", F_BEQ, 32'd5, 32'd5, 32'h40, 32'h200, 1'b1);
        step("beq3", F_BEQ, 32'd5, 32'd5, 32'h40, 32'h200, 1'b1);
        check_pred("beq.pred3", 32'h40, 1'b1);
        step("bne1", F_BNE, 32'd9, 32'd9, 32'h40, 32'h200, 1'b1);
        check_pred("bne1.pred", 32'h40, 1'b1);

        // Same-cycle lookup and update: old value now, new value after the edge
        issue(F_BNE, 32'd9, 32'd9, 32'h40, 32'h200, 1'b1);
        check_pred("coll.old", 32'h40, 1'b1);
        cycle();
        check_res("bne2");
        check_pred("coll.new", 32'h40, 1'b0);

        // Alias: 0x140 trains the entry seen by 0x40
        step("alias", F_BEQ, 32'd3, 32'd3, 32'h140, 32'h500, 1'b0);
        check_pred("alias.pred", 32'h40, 1'b1);

        // Stall with a valid branch: nothing moves for three cycles
        ex_stall = 1'b1;
        drive(F_BNE, 32'd4, 32'd4, 32'h40, 32'h600, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall.valid",   res_valid,       1'b1);
            chk("stall.taken",   res_taken,       last_exp.taken);
            chk("stall.mispred", res_mispredict,  last_exp.mispred);
            chk("stall.redir",   res_redirect_pc, last_exp.redir);
            chk("stall.perf",    perf_branches,   32'(exp_br));
            check_pred("stall.pred", 32'h40, 1'b1);
        end
        ex_stall = 1'b0;
        issue(F_BNE, 32'd4, 32'd4, 32'h40, 32'h600, 1'b1);
        cycle();
        check_res("unstall");
        ex_valid = 1'b0;
        cycle();
        chk("unstall.perf_br", perf_branches, 32'(exp_br));
        chk("unstall.perf_mp", perf_mispred,  32'(exp_mp));
        check_pred("unstall.pred", 32'h40, 1'b0);

        // Illegal encodings leave the BHT untouched
        step("pre_ill", F_BEQ, 32'd1, 32'd1, 32'h40, 32'h300, 1'b0);
        check_pred("pre_ill.pred", 32'h40, 1'b1);
        step("ill010", 3'b010, 32'd1, 32'd1, 32'h40, 32'h300, 1'b1);
        check_pred("ill010.pred", 32'h40, 1'b1);
        step("ill011", 3'b011, 32'd1, 32'd1, 32'h40, 32'h300, 1'b0);
        check_pred("ill011.pred", 32'h40, 1'b1);
        chk("ill.perf_br", perf_branches, 32'(exp_br));
        chk("ill.perf_mp", perf_mispred,  32'(exp_mp));

        // Twenty mispredicts saturate the 4-bit counters
        for (int k = 0; k < 20; k++) step("sat", F_BEQ, 32'd7, 32'd7, 32'h80, 32'h400, 1'b0);
        chk("sat.small_mp", s_perf_mispred,  4'hF);
        chk("sat.small_br", s_perf_branches, 4'hF);
        chk("sat.main_mp",  perf_mispred,    32'(exp_mp));
        chk("sat.main_br",  perf_branches,   32'(exp_br));
        check_pred("sat.pred", 32'h80, 1'b1);

        // Reset mid-capture clears results immediately and discards the in-flight branch
        drive(F_BEQ, 32'd2, 32'd2, 32'h80, 32'h440, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid",   res_valid,       1'b0);
        chk("arst.taken",   res_taken,       1'b0);
        chk("arst.mispred", res_mispredict,  1'b0);
        chk("arst.redir",   res_redirect_pc, 32'd0);
        chk("arst.illegal", res_illegal,     1'b0);
        chk("arst.perf_br", perf_branches,   32'd0);
        chk("arst.small_mp", s_perf_mispred, 4'd0);
        check_pred("arst.pred", 32'h80, 1'b0);
        cycle();
        ex_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst.valid", res_valid, 1'b0);
        chk("post_rst.perf",  perf_branches, 32'd0);
        chk("sb.drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
